// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline: the machine word, the MEM-stage controller
// states and the watchdog default.
package cpu_types_pkg;

  localparam int WORD_BITS       = 32;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_I,
    HALTED
  } memctrl_state_t;

endpackage

// File: rtl/mem_stage_ctrl_link_reg.sv
// LL/SC reservation: one linked address with store/SC, failed-SC and snoop
// invalidation. link_hit is the raw full-width address compare against addr.
module link_reg
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = WORD_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] addr,
  input  logic              set,
  input  logic              clr,
  input  logic              clr_on_match,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              link_hit,
  output logic              link_valid
);

  logic [WORD_W-1:0] link_addr;
  logic              store_kill;
  logic              snoop_kill;

  assign link_hit   = (link_addr == addr);
  assign store_kill = clr_on_match & link_hit;
  assign snoop_kill = snoop_inv & (snoop_addr == link_addr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      // A snoop of the very address being linked kills the new reservation.
      link_valid <= !(snoop_inv && (snoop_addr == addr));
      link_addr  <= addr;
    end else if (clr || store_kill || snoop_kill) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: issues dcache requests for the EX/MEM op, waits for the
// fetch side to line up, and drives the global pipeline enable and freeze.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = WORD_BITS,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              datomic,
  input  logic              halt,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] rdat2,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] mem_data,
  output logic              pipe_en,
  output logic              exmem_freeze,
  output logic              halt_o,
  output logic              err_timeout
);

  localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

  memctrl_state_t     state, state_d;
  logic [WORD_W-1:0]  cap_data, cap_data_d;
  logic [WORD_W-1:0]  acc_data;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               err_q, err_d;
  logic               memop, is_sc, sc_fail;
  logic               link_hit, link_valid;
  logic               link_set, link_clr, link_store_done;

  assign memop    = mem_read | mem_write;
  assign is_sc    = datomic & mem_write;
  assign sc_fail  = is_sc & ~(link_valid & link_hit);
  assign acc_data = is_sc ? WORD_W'(1) : dmemload;

  assign dmemaddr    = alu_out;
  assign dmemstore   = rdat2;
  assign halt_o      = (state == HALTED);
  assign err_timeout = err_q;

  link_reg #(.WORD_W(WORD_W)) u_link (
    .clk          (CLK),
    .rst_n        (nRST),
    .addr         (alu_out),
    .set          (link_set),
    .clr          (link_clr),
    .clr_on_match (link_store_done),
    .snoop_inv    (snoop_inv),
    .snoop_addr   (snoop_addr),
    .link_hit     (link_hit),
    .link_valid   (link_valid)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d         = state;
    cap_data_d      = cap_data;
    dmemREN         = 1'b0;
    dmemWEN         = 1'b0;
    mem_data        = '0;
    pipe_en         = 1'b0;
    exmem_freeze    = 1'b0;
    link_set        = 1'b0;
    link_clr        = 1'b0;
    link_store_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (halt && !memop) begin
          state_d = HALTED;
        end else if (memop && !sc_fail) begin
          state_d      = ACCESS;
          exmem_freeze = 1'b1;
        end else if (sc_fail) begin
          link_clr = 1'b1;
          pipe_en  = ihit;
          if (!ihit) begin
            state_d    = WAIT_I;
            cap_data_d = '0;
          end
        end else begin
          pipe_en = ihit;
        end
      end
      ACCESS: begin
        // EX/MEM is frozen, so the request can come straight off its outputs.
        dmemREN      = mem_read;
        dmemWEN      = mem_write;
        exmem_freeze = 1'b1;
        if (dhit) begin
          link_set        = datomic & mem_read;
          link_store_done = mem_write;
          if (ihit) begin
            mem_data     = acc_data;
            pipe_en      = 1'b1;
            exmem_freeze = 1'b0;
            state_d      = IDLE;
          end else begin
            cap_data_d = acc_data;
            state_d    = WAIT_I;
          end
        end
      end
      WAIT_I: begin
        // Freeze drops with the enable so the completed op leaves EX/MEM.
        mem_data     = cap_data;
        exmem_freeze = !ihit;
        if (ihit) begin
          pipe_en = 1'b1;
          state_d = IDLE;
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  // Timer holds the number of ACCESS cycles including the upcoming one.
  always_comb begin
    timer_d = '0;
    err_d   = err_q;
    if (state_d == ACCESS)
      timer_d = (timer == TIMER_MAX) ? timer : timer + 1'b1;
    if ((TIMEOUT != 0) && (state_d == ACCESS) && (timer_d == TIMER_MAX))
      err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cap_data <= '0;
      timer    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cap_data <= cap_data_d;
      timer    <= timer_d;
      err_q    <= err_d;
    end
  end

endmodule
